// File: rtl/gf2_pkg.sv
// Shared GF(2) matrix-multiply definitions: sequencer state type and the
// gfm_mac command encodings used by the sequencer and by MAC users.
package gf2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_FLUSH = 2'd3
  } gfm_state_t;

  // MAC command field: bit 1 marks a writing command, bit 0 picks load vs. XOR.
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_ACC  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  // True when a command changes the MAC register (accumulate or load).
  function automatic logic sel_writes(input logic [1:0] sel);
    return sel[1];
  endfunction

endpackage

// File: rtl/gfm_mac.sv
// GF(2) accumulator driven by gfm_seq: loads the top operand or XORs in the
// side operand when enabled; holds otherwise.
module gfm_mac
  import gf2_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic [1:0]   sel,
  input  logic [N-1:0] load_top,
  input  logic [N-1:0] load_side,
  output logic [N-1:0] acc
);

  logic [N-1:0] acc_q;
  logic [N-1:0] acc_d;

  // Next accumulator value from the current command.
  always_comb begin
    acc_d = acc_q;
    if (clk_en && sel_writes(sel)) begin
      if (sel == SEL_LOAD) begin
        acc_d = load_top;
      end else begin
        acc_d = acc_q ^ load_side;
      end
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/gfm_seq.sv
// GF(2) vector-matrix sequencer: streams N matrix rows and issues registered
// commands to a downstream gfm_mac so that, at done, the MAC holds the XOR of
// the rows selected by the latched vector.
module gfm_seq
  import gf2_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  input  logic         row_valid,
  input  logic [N-1:0] row_data,
  output logic         row_ready,
  output logic         mac_clk_en,
  output logic [1:0]   mac_sel,
  output logic [N-1:0] mac_load_top,
  output logic [N-1:0] mac_load_side
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  gfm_state_t   state_q, state_d;
  logic [N-1:0] vec_q, vec_d;
  logic [IW-1:0] idx_q, idx_d;
  logic         done_q, done_d;
  logic         en_q, en_d;
  logic [1:0]   sel_q, sel_d;
  logic [N-1:0] top_q, top_d;
  logic [N-1:0] side_q, side_d;
  logic         xfer;

  assign row_ready = (state_q == ST_ACCUM);
  assign xfer      = row_ready && row_valid;

  // Next-state and next-command logic; every command defaults to idle.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    en_d    = 1'b0;
    sel_d   = SEL_HOLD;
    top_d   = '0;
    side_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d   = vec;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // Zero the MAC by loading an all-zero top operand.
        en_d    = 1'b1;
        sel_d   = SEL_LOAD;
        idx_d   = '0;
        state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (xfer) begin
          // Unselected rows are still consumed to keep the stream aligned.
          if (vec_q[idx_q]) begin
            en_d   = 1'b1;
            sel_d  = SEL_ACC;
            side_d = row_data;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_FLUSH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // The last row's command lands in the MAC at this edge.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and registered-command flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= SEL_HOLD;
      top_q   <= '0;
      side_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      top_q   <= top_d;
      side_q  <= side_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign mac_clk_en    = en_q;
  assign mac_sel       = sel_q;
  assign mac_load_top  = top_q;
  assign mac_load_side = side_q;

endmodule

// File: tb/tb_gfm_seq.sv
// Directed bench for gfm_seq (N=4) paired with gfm_mac.
module tb_gfm_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mac_rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] vec = '0;
  logic         busy;
  logic         done;
  logic         row_valid = 1'b0;
  logic [N-1:0] row_data = '0;
  logic         row_ready;
  logic         mac_clk_en;
  logic [1:0]   mac_sel;
  logic [N-1:0] mac_load_top;
  logic [N-1:0] mac_load_side;
  logic [N-1:0] mac_acc;

  int n_checks = 0;
  int n_fail = 0;

  gfm_seq #(.N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .vec           (vec),
    .busy          (busy),
    .done          (done),
    .row_valid     (row_valid),
    .row_data      (row_data),
    .row_ready     (row_ready),
    .mac_clk_en    (mac_clk_en),
    .mac_sel       (mac_sel),
    .mac_load_top  (mac_load_top),
    .mac_load_side (mac_load_side)
  );

  gfm_mac #(.N(N)) mac (
    .clk       (clk),
    .reset     (mac_rst),
    .clk_en    (mac_clk_en),
    .sel       (mac_sel),
    .load_top  (mac_load_top),
    .load_side (mac_load_side),
    .acc       (mac_acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vec;
    logic [15:0] rows;      // row k in bits [4k+3:4k]
    int          gap_row;   // row preceded by a valid-low gap (-1: none)
    int          gap_len;   // ACCUM cycles of that gap
    int          pulse_cyc; // cycle of a stray start with vec=F (0: none)
    logic [3:0]  exp_res;
    int          exp_done;  // done cycle, start cycle = 0
    int          exp_en;    // mac_clk_en cycles seen before done
  } op_t;

  op_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; entered and left 1 time unit after a rising edge.
  task automatic run_op(input int id, input op_t t);
    int cyc, k, stalled, en_cnt, busy_bad, top_bad;
    logic got_done, cur_valid, cur_ready;
    logic [1:0] sel_c2;
    start = 1'b1;
    vec = t.vec;
    row_valid = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    k = 0; stalled = 0; en_cnt = 0; busy_bad = 0; top_bad = 0;
    got_done = 1'b0;
    sel_c2 = 2'b00;
    while (cyc <= 40) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (!busy) busy_bad++;
      if (mac_clk_en) en_cnt++;
      if (mac_load_top != '0) top_bad++;
      if (cyc == 2) sel_c2 = mac_sel;
      start = (cyc == t.pulse_cyc);
      vec = start ? 4'hF : t.vec;
      if (k < N) begin
        if (k == t.gap_row && stalled < t.gap_len) begin
          row_valid = 1'b0;
          if (row_ready) stalled++;
        end else begin
          row_valid = 1'b1;
          row_data = t.rows[4*k +: 4];
        end
      end else begin
        row_valid = 1'b0;
      end
      cur_valid = row_valid;
      cur_ready = row_ready;
      tick();
      cyc++;
      if (cur_valid && cur_ready) k++;
    end
    start = 1'b0;
    row_valid = 1'b0;
    chk("done_seen", {31'd0, got_done}, 32'd1);
    chk("done_cycle", cyc, t.exp_done);
    chk("result", {28'd0, mac_acc}, {28'd0, t.exp_res});
    chk("rows_consumed", k, N);
    chk("clk_en_cycles", en_cnt, t.exp_en);
    chk("clear_cmd_sel", {30'd0, sel_c2}, 32'd3);
    chk("busy_gaps", busy_bad, 0);
    chk("load_top_zero", top_bad, 0);
    $display("op %0d vec=%b result=%h done_cycle=%0d", id, t.vec, mac_acc, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t t;
    int bad;
    tbl[0] = '{4'b0101, 16'h8421, -1, 0, 0, 4'h5, 7, 3};
    tbl[1] = '{4'b1000, 16'h6000, -1, 0, 0, 4'h6, 7, 2};  // back-to-back after 5
    tbl[2] = '{4'b1111, 16'hF953,  2, 2, 0, 4'h0, 9, 5};
    tbl[3] = '{4'b0000, 16'hDCBA, -1, 0, 0, 4'h0, 7, 1};
    tbl[4] = '{4'b0011, 16'h8421, -1, 0, 3, 4'h3, 7, 3};  // stray start while busy
    tbl[5] = '{4'b0110, 16'h8765,  0, 1, 0, 4'h1, 8, 3};
    tbl[6] = '{4'b1010, 16'h8421, -1, 0, 0, 4'hA, 7, 3};

    // Reset with start and row_valid asserted: reset must win.
    start = 1'b1; vec = 4'hF; row_valid = 1'b1; row_data = 4'h9;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_row_ready", {31'd0, row_ready}, 32'd0);
    chk("rst_clk_en", {31'd0, mac_clk_en}, 32'd0);
    chk("rst_sel", {30'd0, mac_sel}, 32'd0);
    chk("rst_load_top", {28'd0, mac_load_top}, 32'd0);
    chk("rst_load_side", {28'd0, mac_load_side}, 32'd0);
    reset = 1'b0; mac_rst = 1'b0; start = 1'b0; row_valid = 1'b0;
    tick();
    chk("idle_after_rst", {31'd0, busy}, 32'd0);

    // Table ops run back to back: each starts in the previous done cycle.
    for (int i = 0; i < 7; i++) begin
      run_op(i, tbl[i]);
    end

    // Abort mid-operation after two rows have been accepted.
    tick();
    start = 1'b1; vec = 4'hF;
    tick();                                          // cycle 1: CLEAR
    start = 1'b0; row_valid = 1'b1; row_data = 4'h3;
    tick();                                          // cycle 2: row 0 offered
    chk("abort_row_ready", {31'd0, row_ready}, 32'd1);
    tick();                                          // row 0 accepted
    row_data = 4'h5;
    tick();                                          // row 1 accepted
    row_data = 4'h9;
    reset = 1'b1;
    tick();
    reset = 1'b0; row_valid = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_row_ready_low", {31'd0, row_ready}, 32'd0);
    chk("abort_clk_en", {31'd0, mac_clk_en}, 32'd0);
    chk("abort_sel", {30'd0, mac_sel}, 32'd0);
    chk("abort_load_side", {28'd0, mac_load_side}, 32'd0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) bad++;
    end
    chk("abort_no_done", bad, 0);
    $display("abort: partial MAC contents %h", mac_acc);
    t = '{4'b0001, 16'h3217, -1, 0, 0, 4'h7, 7, 2};
    run_op(7, t);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
